// File: rtl/imem_boot_ctrl.sv
// Purpose     : boot loader that streams a program (big-endian byte pairs) into a
//               256x16 instruction memory, then releases the CPU and hands it the memory port.
// Latency     : one WRITE cycle after every second byte. CPU fetch is combinational in RUN.
// Backpressure: ld_ready is high only in LOAD_HI/LOAD_LO. ld_valid stalls of any length are tolerated.
// Ports       : clk/rst (async active-high); ld_* loader stream; cpu_* fetch port + core hold;
//               mem_* instruction memory port (combinational read); busy/done/err/wcount status.
// Option      : IMEM_BOOT_CSUM_EN -- the word carrying ld_last is a 16-bit modulo checksum of the
//               written words and is compared, not written.
module imem_boot_ctrl #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_start,
    input  logic [7:0]  ld_byte,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_last,
    input  logic [7:0]  cpu_addr,
    input  logic        cpu_req,
    output logic        cpu_gnt,
    output logic [15:0] cpu_data,
    output logic        cpu_rst,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  wcount
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        WRITE   = 3'd3,
        RUN     = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  wptr;
    logic [15:0] word;
    logic        last_q;

    // Memory holds 256 words, so wcount bit 8 set means the memory is already full.
    logic wr_full;
    assign wr_full = wcount[8];

    logic is_csum;   // WRITE cycle is carrying the checksum word
    logic csum_ok;

`ifdef IMEM_BOOT_CSUM_EN
    logic [15:0] sum;

    assign is_csum = last_q;
    assign csum_ok = (sum == word);

    // Running modulo-2^16 sum of the words actually written in this load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 16'h0000;
        end else if (ld_start) begin
            sum <= 16'h0000;
        end else if (mem_we) begin
            sum <= sum + word;
        end
    end
`else
    assign is_csum = 1'b0;
    assign csum_ok = 1'b1;
`endif

    // Decoded from the state register, so an asynchronous reset removes
    // mem_we in the same cycle it is asserted.
    assign mem_we    = (state == WRITE) && !is_csum && !wr_full;
    assign mem_addr  = (state == RUN) ? cpu_addr : wptr;
    assign mem_wdata = word;
    assign ld_ready  = (state == LOAD_HI) || (state == LOAD_LO);
    assign busy      = (state == LOAD_HI) || (state == LOAD_LO) || (state == WRITE);
    assign cpu_rst   = (state != RUN);
    assign cpu_gnt   = (state == RUN) && cpu_req;
    assign cpu_data  = (state == RUN) ? mem_rdata : 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wptr   <= START_ADDR;
            word   <= 16'h0000;
            last_q <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            wcount <= 9'd0;
        end else if (ld_start) begin
            // Restart from any state. A WRITE in progress still strobes mem_we
            // this cycle; only its bookkeeping is discarded.
            state  <= LOAD_HI;
            wptr   <= START_ADDR;
            last_q <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            wcount <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                LOAD_HI: begin
                    if (ld_valid) begin
                        word[15:8] <= ld_byte;
                        if (ld_last) begin
                            // Odd byte count: nothing to write for the dangling byte.
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= LOAD_LO;
                        end
                    end
                end
                LOAD_LO: begin
                    if (ld_valid) begin
                        word[7:0] <= ld_byte;
                        last_q    <= ld_last;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (is_csum) begin
                        if (csum_ok) begin
                            done  <= 1'b1;
                            state <= RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (wr_full) begin
                        // 257th word: suppressed by mem_we above.
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wptr   <= wptr + 8'd1;
                        wcount <= wcount + 9'd1;
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= RUN;
                        end else begin
                            state <= LOAD_HI;
                        end
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

`ifdef IMEM_BOOT_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ld_start, ld_valid, ld_last, cpu_req;
    logic [7:0]  ld_byte, cpu_addr;
    logic        ld_ready [2];
    logic        cpu_gnt  [2];
    logic        cpu_rst  [2];
    logic        mem_we   [2];
    logic        busy     [2];
    logic        done     [2];
    logic        err      [2];
    logic [15:0] cpu_data [2];
    logic [15:0] mem_wdata[2];
    logic [15:0] mem_rdata[2];
    logic [7:0]  mem_addr [2];
    logic [8:0]  wcount   [2];

    // Instance 0 loads from 8'h00, instance 1 from 8'hFF (exercises wrap).
    imem_boot_ctrl #(.START_ADDR(8'h00)) u_dut0 (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_byte(ld_byte),
        .ld_valid(ld_valid), .ld_ready(ld_ready[0]), .ld_last(ld_last),
        .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt[0]),
        .cpu_data(cpu_data[0]), .cpu_rst(cpu_rst[0]), .mem_addr(mem_addr[0]),
        .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .wcount(wcount[0])
    );

    imem_boot_ctrl #(.START_ADDR(8'hFF)) u_dut1 (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_byte(ld_byte),
        .ld_valid(ld_valid), .ld_ready(ld_ready[1]), .ld_last(ld_last),
        .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt[1]),
        .cpu_data(cpu_data[1]), .cpu_rst(cpu_rst[1]), .mem_addr(mem_addr[1]),
        .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .wcount(wcount[1])
    );

    // Instruction memories with combinational read plus a log of every write.
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [23:0] wlog0 [$];
    logic [23:0] wlog1 [$];

    assign mem_rdata[0] = mem0[mem_addr[0]];
    assign mem_rdata[1] = mem1[mem_addr[1]];

    always @(posedge clk) begin
        if (mem_we[0]) begin
            mem0[mem_addr[0]] <= mem_wdata[0];
            wlog0.push_back({mem_addr[0], mem_wdata[0]});
        end
        if (mem_we[1]) begin
            mem1[mem_addr[1]] <= mem_wdata[1];
            wlog1.push_back({mem_addr[1], mem_wdata[1]});
        end
    end

    // Reference model state
    logic [15:0] exp_mem [2][256];
    bit          exp_vld [2][256];
    logic [15:0] words [$];
    bit          exp_run;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [7:0] start_of(input int k);
        return (k == 0) ? 8'h00 : 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_cpu_rst"}, 32'(cpu_rst[k]), 32'd1);
            chk({tag, "_ld_ready"}, 32'(ld_ready[k]), 32'd0);
            chk({tag, "_cpu_gnt"}, 32'(cpu_gnt[k]), 32'd0);
            chk({tag, "_cpu_data"}, 32'(cpu_data[k]), 32'd0);
            chk({tag, "_mem_we"}, 32'(mem_we[k]), 32'd0);
            chk({tag, "_mem_addr"}, 32'(mem_addr[k]), 32'(start_of(k)));
            chk({tag, "_mem_wdata"}, 32'(mem_wdata[k]), 32'd0);
            chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
            chk({tag, "_done"}, 32'(done[k]), 32'd0);
            chk({tag, "_err"}, 32'(err[k]), 32'd0);
            chk({tag, "_wcount"}, 32'(wcount[k]), 32'd0);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the
    // edge on which the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit last);
        int cnt;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
        ld_byte  = b;
        ld_last  = last;
        ld_valid = 1'b1;
        cnt = 0;
        while (!ld_ready[0] && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 50) chk("ready_timeout", 32'(ld_ready[0]), 32'd1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_byte  = $urandom_range(0, 255);
    endtask

    // Loads the global 'words' list, optionally with a dangling odd byte or a
    // corrupted checksum, then checks the outcome against the model.
    task automatic do_load(input string tag, input bit odd, input bit bad_csum);
        int n, nw, base0, base1, bad, cnt;
        logic [15:0] sum, csum;
        bit e_done, e_err;
        int e_wc;
        n = words.size();
        nw = (n > 256) ? 256 : n;
        sum = 16'h0000;
        for (int i = 0; i < nw; i++) sum = sum + words[i];
        csum = bad_csum ? sum + 16'h0001 : sum;

        if (odd) begin
            e_done = 0; e_err = 1; e_wc = nw;
        end else if (n > 256) begin
            e_done = 0; e_err = 1; e_wc = 256;
        end else if (CSUM && bad_csum) begin
            e_done = 0; e_err = 1; e_wc = n;
        end else begin
            e_done = 1; e_err = 0; e_wc = n;
        end

        base0 = wlog0.size();
        base1 = wlog1.size();
        pulse_start();
        chk({tag, "_load_gnt"}, 32'(cpu_gnt[0] | cpu_gnt[1]), 32'd0);
        chk({tag, "_load_cpu_rst"}, 32'(cpu_rst[0] & cpu_rst[1]), 32'd1);
        chk({tag, "_load_busy"}, 32'(busy[0]), 32'd1);

        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8], 1'b0);
            send_byte(words[i][7:0], !CSUM && !odd && (i == n - 1));
        end
        if (odd) begin
            send_byte(8'hAB, 1'b1);
        end else if (CSUM && n <= 256) begin
            send_byte(csum[15:8], 1'b0);
            send_byte(csum[7:0], 1'b1);
        end

        cnt = 0;
        while (busy[0] && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_settle"}, 32'(busy[0]), 32'd0);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < nw; i++) begin
                exp_mem[k][8'(start_of(k) + 8'(i))] = words[i];
                exp_vld[k][8'(start_of(k) + 8'(i))] = 1'b1;
            end
        end
        chk({tag, "_nwr0"}, 32'(wlog0.size() - base0), 32'(nw));
        chk({tag, "_nwr1"}, 32'(wlog1.size() - base1), 32'(nw));
        bad = 0;
        for (int i = 0; i < nw && base0 + i < wlog0.size() && base1 + i < wlog1.size(); i++) begin
            if (wlog0[base0 + i] !== {8'(start_of(0) + 8'(i)), words[i]}) bad++;
            if (wlog1[base1 + i] !== {8'(start_of(1) + 8'(i)), words[i]}) bad++;
        end
        chk({tag, "_wr_content"}, 32'(bad), 32'd0);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_done"}, 32'(done[k]), 32'(e_done));
            chk({tag, "_err"}, 32'(err[k]), 32'(e_err));
            chk({tag, "_wcount"}, 32'(wcount[k]), 32'(e_wc));
            chk({tag, "_cpu_rst"}, 32'(cpu_rst[k]), 32'(!e_done));
        end
        exp_run = e_done;
    endtask

    task automatic do_fetch(input string tag);
        logic [7:0] a;
        bit req;
        for (int j = 0; j < 4; j++) begin
            a   = (words.size() > 0) ? 8'($urandom_range(0, words.size() - 1)) : 8'h00;
            req = (j != 3);
            cpu_addr = a;
            cpu_req  = req;
            #1;
            for (int k = 0; k < 2; k++) begin
                chk({tag, "_gnt"}, 32'(cpu_gnt[k]), 32'(exp_run && req));
                if (!exp_run)
                    chk({tag, "_data_idle"}, 32'(cpu_data[k]), 32'd0);
                else if (exp_vld[k][a])
                    chk({tag, "_data"}, 32'(cpu_data[k]), 32'(exp_mem[k][a]));
            end
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) exp_vld[k][a] = 1'b0;
        exp_run  = 1'b0;
        rst      = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_byte  = 8'h00;
        cpu_req  = 1'b1;
        cpu_addr = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_req = 1'b0;

        // Basic load; cpu_req held high during the load must not be granted.
        cpu_req = 1'b1;
        words = '{16'h1234, 16'h5678};
        if (CSUM) words = '{16'h0001, 16'h0002};
        do_load("basic", 1'b0, 1'b0);
        cpu_addr = 8'h01;
        cpu_req  = 1'b1;
        #1;
        chk("fetch01_gnt", 32'(cpu_gnt[0]), 32'd1);
        chk("fetch01_data", 32'(cpu_data[0]), CSUM ? 32'h0002 : 32'h5678);
        cpu_req = 1'b0;
        #1;
        chk("fetch01_noreq", 32'(cpu_gnt[0]), 32'd0);
        do_fetch("basic_fetch");

        // Restart from RUN.
        pulse_start();
        chk("restart_cpu_rst", 32'(cpu_rst[0]), 32'd1);
        chk("restart_wcount", 32'(wcount[0]), 32'd0);
        chk("restart_done", 32'(done[0]), 32'd0);
        chk("restart_busy", 32'(busy[0]), 32'd1);

        if (CSUM) begin
            words = '{16'h0001, 16'h0002};
            do_load("csum_bad", 1'b0, 1'b1);
        end

        // Single odd byte.
        words = {};
        do_load("odd", 1'b1, 1'b0);
        do_fetch("odd_fetch");

        // Randomised loads.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 12);
            words = {};
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            do_load("rand", ($urandom_range(0, 5) == 0), CSUM && ($urandom_range(0, 1) == 1));
            do_fetch("rand_fetch");
        end

        // Overflow: 257 words.
        words = {};
        for (int i = 0; i < 257; i++) words.push_back(16'($urandom));
        do_load("ovf", 1'b0, 1'b0);

        // Reset asserted during a WRITE cycle.
        pulse_start();
        send_byte(8'hC3, 1'b0);
        send_byte(8'h5A, 1'b0);
        chk("midwr_we", 32'(mem_we[0] & mem_we[1]), 32'd1);
        begin
            int b0, b1;
            b0 = wlog0.size();
            b1 = wlog1.size();
            #1 rst = 1'b1;
            #1 check_reset_vals("midwr");
            @(posedge clk); #1;
            rst = 1'b0;
            chk("midwr_nowr", 32'((wlog0.size() - b0) + (wlog1.size() - b1)), 32'd0);
        end

        // Recovery load after reset.
        words = {};
        for (int i = 0; i < 5; i++) words.push_back(16'($urandom));
        do_load("recover", 1'b0, 1'b0);
        do_fetch("recover_fetch");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter START_ADDR, default 8'h00: first instruction-memory address written by a load.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ld_start  in  1  pulse that begins a program load.
REQ-005 SHALL have port ld_byte  in  8  loader byte stream, high byte of each word first.
REQ-006 SHALL have ports ld_valid  in  1 and ld_ready  out  1  byte handshake; a byte transfers when both are high.
REQ-007 SHALL have port ld_last  in  1  qualifies the transferring byte as the final byte of the load.
REQ-008 SHALL have ports cpu_addr  in  8, cpu_req  in  1, cpu_gnt  out  1, cpu_data  out  16  CPU fetch port.
REQ-009 SHALL have port cpu_rst  out  1  active-high hold of the CPU core.
REQ-010 SHALL have ports mem_addr  out  8, mem_we  out  1, mem_wdata  out  16, mem_rdata  in  16  to the 256x16 instruction memory (combinational read).
REQ-011 SHALL have ports busy  out  1, done  out  1, err  out  1, wcount  out  9  (words written by current/last load).

Function
REQ-012 SHALL implement states IDLE, LOAD_HI, LOAD_LO, WRITE, RUN.
REQ-013 IDLE: cpu_rst=1, ld_ready=0; ld_start -> LOAD_HI, clears wcount, done, err, loads write pointer with START_ADDR.
REQ-014 LOAD_HI: ld_ready=1; on transfer, capture byte as word[15:8] -> LOAD_LO; if ld_last on this byte, set err -> IDLE (odd byte count, nothing written).
REQ-015 LOAD_LO: ld_ready=1; on transfer, capture byte as word[7:0], record ld_last -> WRITE.
REQ-016 WRITE: exactly one cycle, mem_we=1, mem_addr=write pointer, mem_wdata=assembled word; pointer increments modulo 256; wcount increments.
REQ-017 After WRITE: recorded last -> RUN with done=1; otherwise -> LOAD_HI.
REQ-018 Pointer wrap 8'hFF->8'h00 SHALL be permitted; a 257th word (wcount already 256 on entering WRITE) SHALL NOT be written, err=1 -> IDLE.
REQ-019 RUN: cpu_rst=0, mem_addr=cpu_addr, mem_we=0, cpu_gnt=cpu_req same cycle, cpu_data=mem_rdata.
REQ-020 Outside RUN: cpu_gnt=0, cpu_data=16'h0000, cpu_rst=1.
REQ-021 ld_start in RUN or any LOAD/WRITE state SHALL restart the load (as REQ-013) next cycle; an in-flight WRITE cycle completes first.
REQ-022 busy=1 in LOAD_HI, LOAD_LO, WRITE; 0 otherwise. done, err sticky until next ld_start or reset.
REQ-023 ld_valid with ld_ready=0 SHALL be ignored; stalls of any length on ld_valid SHALL be tolerated.

Reset
REQ-024 rst SHALL force IDLE immediately: cpu_rst=1, ld_ready=0, cpu_gnt=0, cpu_data=0, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, busy=0, done=0, err=0, wcount=0.
REQ-025 rst during WRITE SHALL suppress mem_we asynchronously; memory contents are not touched by this block's reset.

Configuration
REQ-026 With IMEM_BOOT_CSUM_EN defined, the word carrying ld_last SHALL be a checksum, not written; running 16-bit modulo sum of written words compared to it: match -> RUN, done=1; mismatch -> err=1, IDLE. wcount excludes the checksum word.
REQ-027 Without IMEM_BOOT_CSUM_EN, no checksum logic; the last word is written per REQ-016/017.

Verification
REQ-028 Reset, ld_start, bytes 12 34 56 78(last), no macro -> mem writes 0x00=16'h1234, 0x01=16'h5678; RUN, done=1, wcount=2, cpu_rst=0.
REQ-029 In RUN, cpu_req=1, cpu_addr=8'h01 -> cpu_gnt=1, cpu_data=16'h5678 same cycle; during load cpu_req=1 -> cpu_gnt=0.
REQ-030 Bytes AB(last) -> err=1, IDLE, no mem_we pulse, wcount=0.
REQ-031 START_ADDR=8'hFF, two words -> writes at 8'hFF then 8'h00; 257 words -> err=1, only 256 writes.
REQ-032 rst asserted mid-WRITE -> mem_we drops same cycle, all outputs at REQ-024 values; ld_start in RUN -> cpu_rst=1, wcount=0 next cycle.
REQ-033 IMEM_BOOT_CSUM_EN: words 0001 0002, checksum 0003 -> done=1, wcount=2; checksum 0004 -> err=1, IDLE.
